mem_req_arbiter: RTL and testbench

- Arbitrates the instruction-fetch and data-access SRAM-like request channels (req/addr_ok/data_ok) onto one shared memory port.
- Sits between the IF and EXE/MEM stages and the memory bridge, and replaces their direct SRAM connections.
- Tracks the source of every outstanding transaction in an in-order ID FIFO. Each response is routed back to the requester that issued it.

---
 rtl/mem_req_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_req_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Arbitrates the instruction-fetch and data-access request channels onto one shared memory port.
// An in-order source-ID FIFO routes each response back to the channel that issued the request.
module mem_req_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [3:0]        inst_wstrb,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [3:0]        data_wstrb,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              resp_err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_D = 2'd1,
    HOLD_I = 2'd2
  } state_t;

  state_t state, state_next;

  logic [MAX_OUTSTANDING-1:0] id_fifo;
  logic [PTR_W-1:0]           rd_ptr, wr_ptr;
  logic [CNT_W-1:0]           count;

  logic full, gnt_valid, gnt_data, accept, pop, head_is_data;

  assign full = (count == FULL_CNT);

  // A held channel keeps the port until accepted; full only masks mem_req, never the ownership.
  always_comb begin
    state_next = state;
    gnt_valid  = 1'b0;
    gnt_data   = 1'b0;
    case (state)
      IDLE: begin
        if (!full) begin
          if (data_req) begin
            gnt_valid = 1'b1;
            gnt_data  = 1'b1;
          end else if (inst_req) begin
            gnt_valid = 1'b1;
          end
        end
        if (gnt_valid && !mem_addr_ok)
          state_next = gnt_data ? HOLD_D : HOLD_I;
      end
      HOLD_D: begin
        gnt_valid = !full;
        gnt_data  = 1'b1;
        if (gnt_valid && mem_addr_ok)
          state_next = IDLE;
      end
      HOLD_I: begin
        gnt_valid = !full;
        if (gnt_valid && mem_addr_ok)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req   = gnt_valid;
  assign mem_wr    = gnt_data ? data_wr    : inst_wr;
  assign mem_size  = gnt_data ? data_size  : inst_size;
  assign mem_addr  = gnt_data ? data_addr  : inst_addr;
  assign mem_wstrb = gnt_data ? data_wstrb : inst_wstrb;
  assign mem_wdata = gnt_data ? data_wdata : inst_wdata;

  assign accept       = gnt_valid & mem_addr_ok;
  assign data_addr_ok = accept & gnt_data;
  assign inst_addr_ok = accept & ~gnt_data;

  assign pop          = mem_data_ok & (count != '0);
  assign head_is_data = id_fifo[rd_ptr];
  assign data_data_ok = pop & head_is_data;
  assign inst_data_ok = pop & ~head_is_data;
  assign data_rdata   = mem_rdata;
  assign inst_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_fifo  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      resp_err <= 1'b0;
    end else begin
      if (accept) begin
        id_fifo[wr_ptr] <= gnt_data;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept && !pop)
        count <= count + CNT_W'(1);
      else if (!accept && pop)
        count <= count - CNT_W'(1);
      if (mem_data_ok && count == '0)
        resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter: priority, hold, full FIFO,
// wrap-around routing, unexpected responses and reset mid-flight.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, data_addr, mem_addr;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_wdata, data_wdata, mem_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.MAX_OUTSTANDING(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .resp_err(resp_err)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h1000_0000;
    inst_wstrb = 4'hf; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 32'h2000_0000;
    data_wstrb = 4'hf; data_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    logic [1:0] st;
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    settle();
    st = dut.state;
    checks++; if (st !== 2'd0) begin errors++; $display("[TB] FAIL reset_state got %0d want 0", st); end
    checks++; if (dut.count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", dut.count); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_err got %b want 0", resp_err); end
    checks++; if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_outputs got %b want 00000",
                         {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    step();
  endtask

  task automatic test_priority();
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    inst_addr = 32'h1000_0040; data_addr = 32'h2000_0080; data_wr = 1; data_wdata = 32'hdead_beef;
    settle();
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin
      errors++; $display("[TB] FAIL prio_addr_ok got d%b i%b want d1 i0", data_addr_ok, inst_addr_ok); end
    checks++; if (mem_addr !== 32'h2000_0080 || mem_wr !== 1'b1 || mem_wdata !== 32'hdead_beef) begin
      errors++; $display("[TB] FAIL prio_mem_fields got %h/%b/%h want 20000080/1/deadbeef", mem_addr, mem_wr, mem_wdata); end
    step();
    data_req = 0; data_wr = 0;
    settle();
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b01 || mem_addr !== 32'h1000_0040) begin
      errors++; $display("[TB] FAIL prio_inst_next got d%b i%b addr %h want d0 i1 10000040",
                         data_addr_ok, inst_addr_ok, mem_addr); end
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0000_00a1;
    settle();
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10 || data_rdata !== 32'h0000_00a1) begin
      errors++; $display("[TB] FAIL prio_resp1 got d%b i%b rdata %h want d1 i0 000000a1",
                         data_data_ok, inst_data_ok, data_rdata); end
    step();
    mem_rdata = 32'h0000_00a2;
    settle();
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b01 || inst_rdata !== 32'h0000_00a2) begin
      errors++; $display("[TB] FAIL prio_resp2 got d%b i%b rdata %h want d0 i1 000000a2",
                         data_data_ok, inst_data_ok, inst_rdata); end
    step();
    mem_data_ok = 0;
    settle();
    checks++; if (dut.count !== 3'd0) begin errors++; $display("[TB] FAIL prio_drained got %0d want 0", dut.count); end
    step();
  endtask

  task automatic test_hold();
    inst_req = 1; inst_addr = 32'h1000_0100; data_addr = 32'h2000_0200; mem_addr_ok = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) data_req = 1;
      settle();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000_0100 || {data_addr_ok, inst_addr_ok} !== 2'b00) begin
        errors++; $display("[TB] FAIL hold_cycle%0d got req %b addr %h d%b i%b want 1 10000100 d0 i0",
                           c, mem_req, mem_addr, data_addr_ok, inst_addr_ok); end
      step();
    end
    mem_addr_ok = 1;
    settle();
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b01 || mem_addr !== 32'h1000_0100) begin
      errors++; $display("[TB] FAIL hold_accept got d%b i%b addr %h want d0 i1 10000100",
                         data_addr_ok, inst_addr_ok, mem_addr); end
    step();
    inst_req = 0;
    settle();
    checks++; if (data_addr_ok !== 1'b1 || mem_addr !== 32'h2000_0200) begin
      errors++; $display("[TB] FAIL hold_data_after got %b addr %h want 1 20000200", data_addr_ok, mem_addr); end
    step();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h55;
    settle();
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b01) begin
      errors++; $display("[TB] FAIL hold_resp_inst got d%b i%b want d0 i1", data_data_ok, inst_data_ok); end
    step();
    settle();
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin
      errors++; $display("[TB] FAIL hold_resp_data got d%b i%b want d1 i0", data_data_ok, inst_data_ok); end
    step();
    mem_data_ok = 0;
  endtask

  task automatic test_full();
    logic [31:0] a;
    inst_req = 1; mem_addr_ok = 1;
    for (int i = 0; i < 4; i++) begin
      a = 32'h1000_1000 + 32'(4 * i);
      inst_addr = a;
      settle();
      checks++; if (inst_addr_ok !== 1'b1 || mem_addr !== a) begin
        errors++; $display("[TB] FAIL full_fill%0d got ok %b addr %h want 1 %h", i, inst_addr_ok, mem_addr, a); end
      step();
    end
    inst_addr = 32'h1000_1010;
    settle();
    checks++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0 || dut.count !== 3'd4) begin
      errors++; $display("[TB] FAIL full_block got req %b ok %b count %0d want 0 0 4", mem_req, inst_addr_ok, dut.count); end
    step();
    mem_data_ok = 1; mem_rdata = 32'h77;
    settle();
    checks++; if (mem_req !== 1'b0 || inst_addr_ok !== 1'b0 || inst_data_ok !== 1'b1) begin
      errors++; $display("[TB] FAIL full_pop_cycle got req %b ok %b dok %b want 0 0 1", mem_req, inst_addr_ok, inst_data_ok); end
    step();
    mem_data_ok = 0;
    settle();
    checks++; if (dut.count !== 3'd3 || inst_addr_ok !== 1'b1 || mem_addr !== 32'h1000_1010) begin
      errors++; $display("[TB] FAIL full_resume got count %0d ok %b addr %h want 3 1 10001010",
                         dut.count, inst_addr_ok, mem_addr); end
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++; if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
        errors++; $display("[TB] FAIL full_drain%0d got i%b d%b want i1 d0", i, inst_data_ok, data_data_ok); end
      step();
    end
    mem_data_ok = 0;
  endtask

  task automatic test_wrap_routing();
    logic [31:0] exp_rdata;
    logic        exp_data_side;
    for (int k = 0; k < 12; k++) begin
      data_req = 0; inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
      if (k < 10) begin
        mem_addr_ok = 1;
        if (k % 2 == 0) begin data_req = 1; data_addr = 32'h2000_3000 + 32'(k); end
        else begin inst_req = 1; inst_addr = 32'h1000_3000 + 32'(k); end
      end
      if (k >= 2) begin
        mem_data_ok = 1;
        exp_rdata = 32'h100 + 32'(k - 2);
        mem_rdata = exp_rdata;
      end
      settle();
      if (k < 10) begin
        checks++; if ({data_addr_ok, inst_addr_ok} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++; $display("[TB] FAIL wrap_issue%0d got d%b i%b", k, data_addr_ok, inst_addr_ok); end
      end
      if (k >= 2) begin
        exp_data_side = ((k - 2) % 2 == 0);
        checks++; if ({data_data_ok, inst_data_ok} !== {exp_data_side, !exp_data_side} ||
                      (exp_data_side ? data_rdata : inst_rdata) !== exp_rdata) begin
          errors++; $display("[TB] FAIL wrap_resp%0d got d%b i%b rdata %h/%h want side_data=%b rdata %h",
                             k - 2, data_data_ok, inst_data_ok, data_rdata, inst_rdata, exp_data_side, exp_rdata); end
      end
      step();
    end
    clear_inputs();
    settle();
    checks++; if (dut.count !== 3'd0) begin errors++; $display("[TB] FAIL wrap_drained got %0d want 0", dut.count); end
    step();
  endtask

  task automatic test_unexpected_resp();
    mem_data_ok = 1; mem_rdata = 32'hbad;
    settle();
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b00) begin
      errors++; $display("[TB] FAIL unexp_pulse got d%b i%b want d0 i0", data_data_ok, inst_data_ok); end
    step();
    mem_data_ok = 0;
    settle();
    checks++; if (resp_err !== 1'b1 || dut.count !== 3'd0) begin
      errors++; $display("[TB] FAIL unexp_flag got err %b count %0d want 1 0", resp_err, dut.count); end
    repeat (3) step();
    settle();
    checks++; if (resp_err !== 1'b1) begin errors++; $display("[TB] FAIL unexp_sticky got %b want 1", resp_err); end
    step();
  endtask

  task automatic test_reset_midflight();
    logic [1:0] st;
    mem_addr_ok = 1; inst_req = 1;
    step();
    inst_req = 0; data_req = 1;
    step();
    data_req = 0; inst_req = 1; mem_addr_ok = 0;
    settle();
    checks++; if (dut.count !== 3'd2) begin errors++; $display("[TB] FAIL mid_count got %0d want 2", dut.count); end
    step();
    reset = 1;
    clear_inputs();
    step();
    reset = 0;
    settle();
    st = dut.state;
    checks++; if (st !== 2'd0 || dut.count !== 3'd0 || resp_err !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset got state %0d count %0d err %b want 0 0 0", st, dut.count, resp_err); end
    checks++; if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
      errors++; $display("[TB] FAIL mid_outputs got %b want 00000",
                         {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    step();
    mem_data_ok = 1;
    settle();
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b00) begin
      errors++; $display("[TB] FAIL mid_stale_pulse got d%b i%b want d0 i0", data_data_ok, inst_data_ok); end
    step();
    mem_data_ok = 0;
    settle();
    checks++; if (resp_err !== 1'b1) begin errors++; $display("[TB] FAIL mid_stale_err got %b want 1", resp_err); end
    step();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_hold();
    test_full();
    test_wrap_routing();
    test_unexpected_resp();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
